// File: rtl/led_dsm_pkg.sv
// Shared types and helpers for the N-channel LED delta-sigma / PWM modulator.
package led_dsm_pkg;

    typedef enum logic {
        MODE_DSM = 1'b0,
        MODE_PWM = 1'b1
    } mode_e;

    localparam int DEFAULT_WIDTH = 8;

    typedef logic [DEFAULT_WIDTH-1:0] level_t;

    // A single-channel build still needs a 1-bit channel select port.
    function automatic int chw_calc(input int n_ch);
        return (n_ch > 1) ? $clog2(n_ch) : 1;
    endfunction

endpackage

// File: rtl/led_dsm_lane.sv
// One LED channel: delta-sigma accumulator or PWM comparator feeding a registered output.
module led_dsm_lane
    import led_dsm_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             mode,
    input  logic [WIDTH-1:0] level,
    input  logic [WIDTH-1:0] cnt,
    output logic             led
);

    logic [WIDTH-1:0] acc;
    logic [WIDTH:0]   sum;

    // The carry out of the accumulator is the delta-sigma bit stream.
    assign sum = {1'b0, acc} + {1'b0, level};

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            acc <= '0;
            led <= 1'b0;
        end else if (mode == MODE_PWM) begin
            led <= (cnt < level);
        end else begin
            acc <= sum[WIDTH-1:0];
            led <= sum[WIDTH];
        end
    end

endmodule

// File: rtl/led_dsm_nch.sv
// N-channel LED modulator with double-buffered levels and a shared PWM counter.
// Define LED_DSM_FADE_EN to let active levels ramp toward their targets one step per FADE_DIV cycles.
module led_dsm_nch
    import led_dsm_pkg::*;
#(
    parameter  int N_CH     = 3,
    parameter  int WIDTH    = DEFAULT_WIDTH,
    parameter  int FADE_DIV = 256,
    localparam int CHW      = chw_calc(N_CH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             mode,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [CHW-1:0]   wr_ch,
    input  logic [WIDTH-1:0] wr_level,
    input  logic             commit,
    output logic             settled,
    output logic [N_CH-1:0]  led_out
);

    logic [WIDTH-1:0] shadow      [N_CH];
    logic [WIDTH-1:0] shadow_next [N_CH];
    logic [WIDTH-1:0] target      [N_CH];
    logic [WIDTH-1:0] active      [N_CH];
    logic [WIDTH-1:0] cnt;
    logic             mode_q;
    logic             clear;

    if (N_CH < 1 || WIDTH < 2 || WIDTH > 16 || FADE_DIV < 1) begin : g_bad_param
        $error("led_dsm_nch: parameter out of range");
    end

    assign wr_ready = ~rst;
    assign clear    = ~enable | (mode != mode_q);

    // Out-of-range channel numbers match no lane, so those writes are dropped.
    always_comb begin
        shadow_next = shadow;
        for (int i = 0; i < N_CH; i++) begin
            if (wr_valid && wr_ready && (wr_ch == CHW'(i))) begin
                shadow_next[i] = wr_level;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                shadow[i] <= '0;
                target[i] <= '0;
            end
        end else begin
            shadow <= shadow_next;
            if (commit) begin
                target <= shadow_next;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            mode_q <= MODE_DSM;
            cnt    <= '0;
        end else begin
            mode_q <= mode;
            cnt    <= clear ? '0 : cnt + 1'b1;
        end
    end

`ifdef LED_DSM_FADE_EN
    localparam int PW = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;

    logic [PW-1:0]    presc;
    logic             fade_tick;
    logic             all_match;
    logic             settled_q;
    logic [WIDTH-1:0] target_next [N_CH];

    assign fade_tick = (presc == PW'(FADE_DIV - 1));
    assign settled   = settled_q;

    // Steps head for the value being committed this edge so a retarget takes effect at once.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            target_next[i] = commit ? shadow_next[i] : target[i];
        end
    end

    always_comb begin
        all_match = 1'b1;
        for (int i = 0; i < N_CH; i++) begin
            if (active[i] != target[i]) begin
                all_match = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            presc     <= '0;
            settled_q <= 1'b1;
            for (int i = 0; i < N_CH; i++) begin
                active[i] <= '0;
            end
        end else begin
            presc     <= fade_tick ? '0 : presc + 1'b1;
            settled_q <= all_match;
            if (fade_tick) begin
                for (int i = 0; i < N_CH; i++) begin
                    if (active[i] < target_next[i]) begin
                        active[i] <= active[i] + 1'b1;
                    end else if (active[i] > target_next[i]) begin
                        active[i] <= active[i] - 1'b1;
                    end
                end
            end
        end
    end
`else
    assign active  = target;
    assign settled = 1'b1;
`endif

    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        led_dsm_lane #(
            .WIDTH(WIDTH)
        ) u_lane (
            .clk  (clk),
            .rst  (rst),
            .clear(clear),
            .mode (mode),
            .level(active[i]),
            .cnt  (cnt),
            .led  (led_out[i])
        );
    end

endmodule
